multicycle_control: RTL and testbench

- Moore/Mealy control FSM that sequences the multi-cycle RV64 datapath: the shared ALU, register file, unified memory port and the immediate generator.
- Each instruction runs as FETCH, DECODE, then execute/memory/writeback states. The block drives all datapath strobes and the immediate-format select.
- Memory accesses use a ready handshake with a timeout watchdog. The block also keeps a retired-instruction counter.

---
 rtl/multicycle_control.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_control.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle RV64 datapath: sequences fetch/decode/execute,
// drives every datapath strobe, watches memory handshakes and counts retirements.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        iord_o,
  output logic        pc_src_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic [1:0]  imm_sel_o,
  output logic        trap_o,
  output logic [3:0]  state_o,
  output logic [63:0] instret_o
);

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_ADDR   = 4'd3,
    ST_MEM_RD = 4'd4,
    ST_MEM_WR = 4'd5,
    ST_WB_MEM = 4'd6,
    ST_EXEC_R = 4'd7,
    ST_EXEC_I = 4'd8,
    ST_WB_ALU = 4'd9,
    ST_BRANCH = 4'd10,
    ST_TRAP   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  waitCnt_q, waitCnt_d;
  logic              trap_q, trap_d;
  logic [63:0]       instret_q, instret_d;
  logic              retire;
  logic              memWait;
  logic              timeout;

  assign timeout = (waitCnt_q == TIMEOUT_LAST) && !mem_ready_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_RST;
      waitCnt_q <= '0;
      trap_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      trap_q    <= trap_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    iord_o       = 1'b0;
    pc_src_o     = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    imm_sel_o    = 2'b00;
    retire       = 1'b0;
    memWait      = 1'b0;

    case (state_q)
      ST_RST: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = ST_DECODE;
        end else begin
          memWait = 1'b1;
          if (timeout) state_d = ST_TRAP;
        end
      end
      ST_DECODE: begin
        alu_src_b_o = 2'b10;
        imm_sel_o   = 2'b10;
        case (opcode_i)
          OP_LOAD, OP_STORE: state_d = ST_ADDR;
          OP_RTYPE:          state_d = ST_EXEC_R;
          OP_ITYPE:          state_d = ST_EXEC_I;
          OP_BRANCH:         state_d = (funct3_i[2:1] == 2'b00) ? ST_BRANCH : ST_TRAP;
          default:           state_d = ST_TRAP;
        endcase
      end
      ST_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        imm_sel_o   = (opcode_i == OP_STORE) ? 2'b01 : 2'b00;
        state_d     = (opcode_i == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
        if (mem_ready_i) begin
          state_d = ST_WB_MEM;
        end else begin
          memWait = 1'b1;
          if (timeout) state_d = ST_TRAP;
        end
      end
      ST_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
        if (mem_ready_i) begin
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          memWait = 1'b1;
          if (timeout) state_d = ST_TRAP;
        end
      end
      ST_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        retire       = 1'b1;
        state_d      = ST_FETCH;
      end
      ST_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
        state_d     = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = 2'b10;
        state_d     = ST_WB_ALU;
      end
      ST_WB_ALU: begin
        reg_write_o = 1'b1;
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      // BEQ takes the branch on zero, BNE on not-zero; funct3[0] flips the sense.
      ST_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        pc_src_o    = 1'b1;
        pc_write_o  = zero_i ^ funct3_i[0];
        retire      = 1'b1;
        state_d     = ST_FETCH;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_TRAP;
    endcase

    if (state_d != state_q) begin
      waitCnt_d = '0;
    end else if (memWait) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end else begin
      waitCnt_d = waitCnt_q;
    end

    trap_d    = trap_q | (state_d == ST_TRAP);
    instret_d = instret_q + {63'd0, retire};
  end

  assign trap_o    = trap_q;
  assign state_o   = state_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Per-cycle vector bench for multicycle_control: a table of inputs and expected
// state/strobes/counters, checked through an expectation queue at each negedge.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        zero = 1'b0;
  logic        memReady = 1'b0;
  logic        irWrite, pcWrite, iord, pcSrc, memRead, memWrite, regWrite, memToReg;
  logic        aluSrcA, trap;
  logic [1:0]  aluSrcB, aluOp, immSel;
  logic [3:0]  state;
  logic [63:0] instret;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] R   = 7'b0110011;
  localparam logic [6:0] LD  = 7'b0000011;
  localparam logic [6:0] ST  = 7'b0100011;
  localparam logic [6:0] BR  = 7'b1100011;
  localparam logic [6:0] IM  = 7'b0010011;
  localparam logic [6:0] BAD = 7'b1111111;

  // strobe bundle order: {ir_write, pc_write, mem_read, mem_write, reg_write}
  localparam logic [4:0] Z  = 5'b00000;
  localparam logic [4:0] F1 = 5'b11100;
  localparam logic [4:0] F0 = 5'b00100;
  localparam logic [4:0] WR = 5'b00010;
  localparam logic [4:0] RW = 5'b00001;
  localparam logic [4:0] PC = 5'b01000;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        rdy;
    logic        chk;
    logic [3:0]  st;
    logic [4:0]  stb;
    logic [63:0] inst;
    logic        trp;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];

  multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .funct3_i(funct3),
    .zero_i(zero), .mem_ready_i(memReady),
    .ir_write_o(irWrite), .pc_write_o(pcWrite), .iord_o(iord), .pc_src_o(pcSrc),
    .mem_read_o(memRead), .mem_write_o(memWrite), .reg_write_o(regWrite),
    .mem_to_reg_o(memToReg), .alu_src_a_o(aluSrcA), .alu_src_b_o(aluSrcB),
    .alu_op_o(aluOp), .imm_sel_o(immSel), .trap_o(trap), .state_o(state),
    .instret_o(instret)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                              input logic z, input logic rdy, input logic chk,
                              input logic [3:0] st, input logic [4:0] stb,
                              input logic [63:0] inst, input logic trp);
    vec_t v;
    v.rst = rst; v.op = op; v.f3 = f3; v.z = z; v.rdy = rdy; v.chk = chk;
    v.st = st; v.stb = stb; v.inst = inst; v.trp = trp;
    return v;
  endfunction

  // {iord, pc_src, mem_to_reg, alu_src_a, alu_src_b, alu_op, imm_sel} per state
  function automatic logic [9:0] expMux(input logic [3:0] st, input logic [6:0] op);
    case (st)
      4'd1:    return {4'b0000, 2'b01, 2'b00, 2'b00};
      4'd2:    return {4'b0000, 2'b10, 2'b00, 2'b10};
      4'd3:    return {4'b0001, 2'b10, 2'b00, (op == ST) ? 2'b01 : 2'b00};
      4'd4:    return {4'b1000, 2'b00, 2'b00, 2'b00};
      4'd5:    return {4'b1000, 2'b00, 2'b00, 2'b00};
      4'd6:    return {4'b0010, 2'b00, 2'b00, 2'b00};
      4'd7:    return {4'b0001, 2'b00, 2'b10, 2'b00};
      4'd8:    return {4'b0001, 2'b10, 2'b10, 2'b00};
      4'd10:   return {4'b0101, 2'b00, 2'b01, 2'b00};
      default: return 10'd0;
    endcase
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset    = v.rst;
    opcode   = v.op;
    funct3   = v.f3;
    zero     = v.z;
    memReady = v.rdy;
    expQ.push_back(v);
  endtask

  task automatic checkOutput(input int idx);
    vec_t e;
    logic [4:0] gotStb;
    logic [9:0] gotMux, wantMux;
    if (expQ.size() == 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL row%0d queue: got empty expectation queue, required one entry", idx);
      return;
    end
    e = expQ.pop_front();
    if (!e.chk) return;
    gotStb  = {irWrite, pcWrite, memRead, memWrite, regWrite};
    gotMux  = {iord, pcSrc, memToReg, aluSrcA, aluSrcB, aluOp, immSel};
    wantMux = expMux(e.st, e.op);
    checks += 5;
    if (state !== e.st) begin
      errors++;
      $display("[TB] FAIL row%0d state: got %0d required %0d", idx, state, e.st);
    end
    if (gotStb !== e.stb) begin
      errors++;
      $display("[TB] FAIL row%0d strobes: got %b required %b", idx, gotStb, e.stb);
    end
    if (gotMux !== wantMux) begin
      errors++;
      $display("[TB] FAIL row%0d muxes: got %b required %b", idx, gotMux, wantMux);
    end
    if (instret !== e.inst) begin
      errors++;
      $display("[TB] FAIL row%0d instret: got %0d required %0d", idx, instret, e.inst);
    end
    if (trap !== e.trp) begin
      errors++;
      $display("[TB] FAIL row%0d trap: got %b required %b", idx, trap, e.trp);
    end
  endtask

  initial begin
    // R-type with memory always ready
    vecs.push_back(mk(1, R, 0, 0, 1, 0, 0, Z, 0, 0));
    vecs.push_back(mk(0, R, 0, 0, 1, 1, 0, Z, 0, 0));
    vecs.push_back(mk(0, R, 0, 0, 1, 1, 1, F1, 0, 0));
    vecs.push_back(mk(0, R, 0, 0, 1, 1, 2, Z, 0, 0));
    vecs.push_back(mk(0, R, 0, 0, 1, 1, 7, Z, 0, 0));
    vecs.push_back(mk(0, R, 0, 0, 1, 1, 9, RW, 0, 0));
    // load: fetch waits 3 cycles (ready on the last allowed cycle), MEM_RD waits 2
    vecs.push_back(mk(0, LD, 0, 0, 0, 1, 1, F0, 1, 0));
    vecs.push_back(mk(0, LD, 0, 0, 0, 1, 1, F0, 1, 0));
    vecs.push_back(mk(0, LD, 0, 0, 0, 1, 1, F0, 1, 0));
    vecs.push_back(mk(0, LD, 0, 0, 1, 1, 1, F1, 1, 0));
    vecs.push_back(mk(0, LD, 0, 0, 1, 1, 2, Z, 1, 0));
    vecs.push_back(mk(0, LD, 0, 0, 1, 1, 3, Z, 1, 0));
    vecs.push_back(mk(0, LD, 0, 0, 0, 1, 4, F0, 1, 0));
    vecs.push_back(mk(0, LD, 0, 0, 0, 1, 4, F0, 1, 0));
    vecs.push_back(mk(0, LD, 0, 0, 1, 1, 4, F0, 1, 0));
    vecs.push_back(mk(0, LD, 0, 0, 1, 1, 6, RW, 1, 0));
    // branches: BEQ taken, BNE not taken, BNE taken, illegal funct3
    vecs.push_back(mk(0, BR, 0, 1, 1, 1, 1, F1, 2, 0));
    vecs.push_back(mk(0, BR, 0, 1, 1, 1, 2, Z, 2, 0));
    vecs.push_back(mk(0, BR, 0, 1, 1, 1, 10, PC, 2, 0));
    vecs.push_back(mk(0, BR, 1, 1, 1, 1, 1, F1, 3, 0));
    vecs.push_back(mk(0, BR, 1, 1, 1, 1, 2, Z, 3, 0));
    vecs.push_back(mk(0, BR, 1, 1, 1, 1, 10, Z, 3, 0));
    vecs.push_back(mk(0, BR, 1, 0, 1, 1, 1, F1, 4, 0));
    vecs.push_back(mk(0, BR, 1, 0, 1, 1, 2, Z, 4, 0));
    vecs.push_back(mk(0, BR, 1, 0, 1, 1, 10, PC, 4, 0));
    vecs.push_back(mk(0, BR, 2, 0, 1, 1, 1, F1, 5, 0));
    vecs.push_back(mk(0, BR, 2, 0, 1, 1, 2, Z, 5, 0));
    vecs.push_back(mk(0, BR, 2, 0, 1, 1, 11, Z, 5, 1));
    // fetch timeout: four cycles without ready must trap
    vecs.push_back(mk(1, R, 0, 0, 0, 1, 11, Z, 5, 1));
    vecs.push_back(mk(0, R, 0, 0, 0, 1, 0, Z, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, R, 0, 0, 0, 1, 1, F0, 0, 0));
    vecs.push_back(mk(0, R, 0, 0, 0, 1, 11, Z, 0, 1));
    // same wait, but ready arrives on the 4th cycle; then an I-type retires
    vecs.push_back(mk(1, IM, 0, 0, 0, 1, 11, Z, 0, 1));
    vecs.push_back(mk(0, IM, 0, 0, 0, 1, 0, Z, 0, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, IM, 0, 0, 0, 1, 1, F0, 0, 0));
    vecs.push_back(mk(0, IM, 0, 0, 1, 1, 1, F1, 0, 0));
    vecs.push_back(mk(0, IM, 0, 0, 1, 1, 2, Z, 0, 0));
    vecs.push_back(mk(0, IM, 0, 0, 1, 1, 8, Z, 0, 0));
    vecs.push_back(mk(0, IM, 0, 0, 1, 1, 9, RW, 0, 0));
    // illegal opcode: trap sticks for 20 cycles with instret frozen
    vecs.push_back(mk(0, BAD, 0, 0, 1, 1, 1, F1, 1, 0));
    vecs.push_back(mk(0, BAD, 0, 0, 1, 1, 2, Z, 1, 0));
    for (int i = 0; i < 20; i++) vecs.push_back(mk(0, BAD, 0, 1, 1, 1, 11, Z, 1, 1));
    // store completes, then a second store is reset mid-handshake
    vecs.push_back(mk(1, ST, 0, 0, 1, 1, 11, Z, 1, 1));
    vecs.push_back(mk(0, ST, 0, 0, 1, 1, 0, Z, 0, 0));
    vecs.push_back(mk(0, ST, 0, 0, 1, 1, 1, F1, 0, 0));
    vecs.push_back(mk(0, ST, 0, 0, 1, 1, 2, Z, 0, 0));
    vecs.push_back(mk(0, ST, 0, 0, 1, 1, 3, Z, 0, 0));
    vecs.push_back(mk(0, ST, 0, 0, 1, 1, 5, WR, 0, 0));
    vecs.push_back(mk(0, ST, 0, 0, 1, 1, 1, F1, 1, 0));
    vecs.push_back(mk(0, ST, 0, 0, 1, 1, 2, Z, 1, 0));
    vecs.push_back(mk(0, ST, 0, 0, 1, 1, 3, Z, 1, 0));
    vecs.push_back(mk(0, ST, 0, 0, 0, 1, 5, WR, 1, 0));
    vecs.push_back(mk(1, ST, 0, 0, 0, 1, 5, WR, 1, 0));
    vecs.push_back(mk(0, ST, 0, 0, 1, 1, 0, Z, 0, 0));
    vecs.push_back(mk(0, ST, 0, 0, 1, 1, 1, F1, 0, 0));
    vecs.push_back(mk(0, ST, 0, 0, 1, 1, 2, Z, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput(i);
    end

    if (expQ.size() != 0) begin
      errors++;
      checks++;
      $display("[TB] FAIL drain: got %0d leftover expectations, required 0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
